// File: rtl/uart_report_pkg.sv
// Shared constants and types for the FPGA-to-PC report transmitter.
package uart_report_pkg;

    localparam int unsigned DEF_CLK_FREQ  = 100000000;
    localparam int unsigned DEF_BAUD      = 115200;
    localparam logic [7:0]  PKT_HEADER    = 8'hA5;
    localparam int unsigned PKT_BYTES     = 4;
    localparam int unsigned PKT_BYTES_CHK = 5;

    // byte3 layout: {1'b0, dir[1:0], st, w, a, s, d}; pend uses the same bit order
    localparam int unsigned B3_D   = 0;
    localparam int unsigned B3_S   = 1;
    localparam int unsigned B3_A   = 2;
    localparam int unsigned B3_W   = 3;
    localparam int unsigned B3_ST  = 4;
    localparam int unsigned B3_DIR = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_NEXT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser, LSB first. A tx_start seen in the final stop-bit cycle
// chains the next byte with no idle gap.
module uart_byte_tx #(
    parameter int unsigned BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [CW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic [9:0]    sh_q, sh_d;
    logic          act_q, act_d;
    logic          bit_end;

    assign bit_end = act_q && (baud_q == CW'(BAUD_DIV - 1));
    assign tx_done = bit_end && (bit_q == 4'd9);
    assign tx_busy = act_q;
    assign txd     = sh_q[0];

    always_comb begin
        baud_d = baud_q;
        bit_d  = bit_q;
        sh_d   = sh_q;
        act_d  = act_q;
        if (act_q) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
            if (bit_end) begin
                bit_d = bit_q + 4'd1;
                // shifting in ones leaves the line idle-high once the stop bit is out
                sh_d  = {1'b1, sh_q[9:1]};
                if (tx_done) act_d = 1'b0;
            end
        end
        if (tx_start && (!act_q || tx_done)) begin
            baud_d = '0;
            bit_d  = '0;
            sh_d   = {1'b1, tx_data, 1'b0};
            act_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_q <= '0;
            bit_q  <= '0;
            sh_q   <= '1;
            act_q  <= 1'b0;
        end else begin
            baud_q <= baud_d;
            bit_q  <= bit_d;
            sh_q   <= sh_d;
            act_q  <= act_d;
        end
    end

endmodule

// File: rtl/uart_report_tx.sv
// Sends a report packet {HEADER, x, y, {dir, buttons}} whenever tank state or
// button events change. Define UART_REPORT_CHKSUM_EN to append an XOR checksum byte.
module uart_report_tx
    import uart_report_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
    parameter int unsigned BAUD     = DEF_BAUD,
    parameter logic [7:0]  HEADER   = PKT_HEADER
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] x_pos,
    input  logic [4:0] y_pos,
    input  logic [1:0] dir,
    input  logic       bt_w,
    input  logic       bt_a,
    input  logic       bt_s,
    input  logic       bt_d,
    input  logic       bt_st,
    input  logic       force_send,
    output logic       fpga_txd,
    output logic       busy,
    output logic       pkt_done
);

    localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
`ifdef UART_REPORT_CHKSUM_EN
    localparam int unsigned NBYTES = PKT_BYTES_CHK;
`else
    localparam int unsigned NBYTES = PKT_BYTES;
`endif

    state_e     state_q, state_d;
    logic [4:0] x_q, x_d, y_q, y_d;
    logic [1:0] dir_q, dir_d;
    logic [4:0] pend_q, pend_d, btn_q, btn_d;
    logic [2:0] idx_q, idx_d;
    logic [4:0] bt_set;
    logic [7:0] byte1, byte2, byte3, tx_data;
    logic       tx_start, tx_busy, tx_done, trig, last_byte;

    always_comb begin
        bt_set         = '0;
        bt_set[B3_D]   = bt_d;
        bt_set[B3_S]   = bt_s;
        bt_set[B3_A]   = bt_a;
        bt_set[B3_W]   = bt_w;
        bt_set[B3_ST]  = bt_st;
    end

    assign trig      = ({x_pos, y_pos, dir} != {x_q, y_q, dir_q}) || (pend_q != '0) || force_send;
    assign last_byte = (idx_q == 3'(NBYTES - 1));
    assign byte1     = {3'b0, x_q};
    assign byte2     = {3'b0, y_q};
    assign byte3     = {1'b0, dir_q, btn_q};

    // tx_start fires on the edge into SEND/NEXT so the start bit is on the line in that cycle
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        x_d      = x_q;
        y_d      = y_q;
        dir_d    = dir_q;
        btn_d    = btn_q;
        pend_d   = pend_q | bt_set;
        tx_start = 1'b0;
        case (state_q)
            ST_IDLE: if (trig) state_d = ST_LOAD;
            ST_LOAD: begin
                x_d      = x_pos;
                y_d      = y_pos;
                dir_d    = dir;
                btn_d    = pend_q;
                pend_d   = bt_set;
                idx_d    = '0;
                tx_start = 1'b1;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                if (tx_done) begin
                    if (last_byte) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d    = idx_q + 3'd1;
                        tx_start = 1'b1;
                        state_d  = ST_NEXT;
                    end
                end
            end
            ST_NEXT: state_d = ST_SEND;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        case (idx_d)
            3'd0:    tx_data = HEADER;
            3'd1:    tx_data = byte1;
            3'd2:    tx_data = byte2;
            3'd3:    tx_data = byte3;
`ifdef UART_REPORT_CHKSUM_EN
            3'd4:    tx_data = byte1 ^ byte2 ^ byte3;
`endif
            default: tx_data = 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            dir_q   <= '0;
            btn_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            btn_q   <= btn_d;
            pend_q  <= pend_d;
        end
    end

    uart_byte_tx #(.BAUD_DIV(BAUD_DIV)) u_byte_tx (
        .clk      (clk),
        .rst      (rst),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .txd      (fpga_txd),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    assign busy     = (state_q == ST_LOAD) || tx_busy;
    assign pkt_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_uart_report_tx.sv
// Directed bench for uart_report_tx at a reduced bit time (8 cycles per bit).
module tb_uart_report_tx;

    localparam int DIV = 8;
`ifdef UART_REPORT_CHKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] x_pos, y_pos;
    logic [1:0] dir;
    logic       bt_w, bt_a, bt_s, bt_d, bt_st, force_send;
    logic       fpga_txd, busy, pkt_done;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] rx_bytes [$];

    always #5 clk = ~clk;

    uart_report_tx #(.CLK_FREQ(800), .BAUD(100)) dut (
        .clk        (clk),
        .rst        (rst),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .dir        (dir),
        .bt_w       (bt_w),
        .bt_a       (bt_a),
        .bt_s       (bt_s),
        .bt_d       (bt_d),
        .bt_st      (bt_st),
        .force_send (force_send),
        .fpga_txd   (fpga_txd),
        .busy       (busy),
        .pkt_done   (pkt_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Line decoder: samples mid-bit, drops partial bytes on reset.
    initial begin
        int  t;
        bit  act;
        logic [7:0] sh;
        t = 0; act = 0; sh = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                act = 0;
                rx_bytes.delete();
            end else if (!act) begin
                if (!fpga_txd) begin act = 1; t = 0; end
            end else begin
                t++;
                if ((t % DIV == DIV / 2) && t > DIV && t < 9 * DIV) sh = {fpga_txd, sh[7:1]};
                if (t == 9 * DIV + DIV / 2) begin
                    if (fpga_txd) rx_bytes.push_back(sh);
                    act = 0;
                end
            end
        end
    end

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!pkt_done && n < 60 * DIV + 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, {31'b0, pkt_done}, 1);
        @(negedge clk);
    endtask

    task automatic chk_pkt(input string tag, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] b4);
        logic [7:0] exp [$];
        exp = '{8'hA5, b1, b2, b3};
        if (NB == 5) exp.push_back(b4);
        chk({tag, "_len"}, rx_bytes.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), (i < rx_bytes.size()) ? {24'b0, rx_bytes[i]} : 'x,
                {24'b0, exp[i]});
        rx_bytes.delete();
    endtask

    task automatic idle_chk(input string tag, input int cyc);
        int hi;
        hi = 0;
        repeat (cyc) begin
            @(negedge clk);
            if (busy || pkt_done) hi++;
        end
        chk(tag, hi, 0);
    endtask

    initial begin
        int n, bc, seen;
        rst = 1'b1; x_pos = '0; y_pos = '0; dir = '0;
        bt_w = 0; bt_a = 0; bt_s = 0; bt_d = 0; bt_st = 0; force_send = 0;
        repeat (3) @(negedge clk);
        chk("rst_txd", {31'b0, fpga_txd}, 1);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, pkt_done}, 0);

        // packet 1 with line timing
        rst = 1'b0; x_pos = 5'd3; y_pos = 5'd7; dir = 2'd2;
        @(negedge clk);
        chk("load_busy", {31'b0, busy}, 1);
        chk("load_txd", {31'b0, fpga_txd}, 1);
        @(negedge clk);
        chk("start_txd", {31'b0, fpga_txd}, 0);
        n = 0;
        while (fpga_txd == 1'b0 && n < 4 * DIV) begin n++; @(negedge clk); end
        chk("start_len", n, DIV);
        bc = 1 + n;
        while (busy && bc < 100 * DIV) begin bc++; @(negedge clk); end
        chk("busy_len", bc, NB * 10 * DIV + 1);
        chk("p1_done", {31'b0, pkt_done}, 1);
        chk("p1_done_txd", {31'b0, fpga_txd}, 1);
        @(negedge clk);
        chk("p1_done_once", {31'b0, pkt_done}, 0);
        chk_pkt("p1", 8'h03, 8'h07, 8'h40, 8'h44);

        // dir change plus bt_st in one packet, then silence
        dir = 2'd0; bt_st = 1;
        @(negedge clk);
        bt_st = 0;
        wait_done("p2");
        chk_pkt("p2", 8'h03, 8'h07, 8'h10, 8'h14);
        idle_chk("p2_idle", 200);

        // bt_d in LOAD, bt_w during byte1 -> carried to the next packet
        force_send = 1;
        @(negedge clk);
        force_send = 0; bt_d = 1;
        @(negedge clk);
        bt_d = 0;
        repeat (15 * DIV) @(negedge clk);
        bt_w = 1;
        @(negedge clk);
        bt_w = 0;
        wait_done("p3");
        chk_pkt("p3", 8'h03, 8'h07, 8'h00, 8'h04);
        wait_done("p4");
        chk_pkt("p4", 8'h03, 8'h07, 8'h09, 8'h0D);
        idle_chk("p4_idle", 200);

        // reset during byte2
        force_send = 1;
        @(negedge clk);
        force_send = 0;
        @(negedge clk);
        repeat (25 * DIV) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("mid_rst_txd", {31'b0, fpga_txd}, 1);
        chk("mid_rst_busy", {31'b0, busy}, 0);
        seen = pkt_done ? 1 : 0;
        repeat (3) begin
            @(negedge clk);
            if (pkt_done) seen++;
        end
        chk("mid_rst_nodone", seen, 0);
        rst = 0;
        wait_done("p5");
        chk_pkt("p5", 8'h03, 8'h07, 8'h00, 8'h04);

        // dir field, then force_send with static inputs; force_send while busy ignored
        dir = 2'd3;
        wait_done("p6");
        chk_pkt("p6", 8'h03, 8'h07, 8'h60, 8'h64);
        force_send = 1;
        @(negedge clk);
        force_send = 0;
        repeat (12 * DIV) @(negedge clk);
        force_send = 1;
        @(negedge clk);
        force_send = 0;
        wait_done("p7");
        chk_pkt("p7", 8'h03, 8'h07, 8'h60, 8'h64);
        idle_chk("p7_idle", 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
